// File: rtl/fn1_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake and full backpressure.
// Optional saturating narrowing compiled in with `define FN1_MUL_SAT_EN.
module fn1_mul_pipe_hs #(
    parameter int unsigned A_W       = 14,
    parameter int unsigned B_W       = 14,
    parameter int unsigned OUT_W     = 14,
    parameter int unsigned NUM_STAGE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic             busy
);

    localparam int unsigned PW = A_W + B_W;
`ifdef FN1_MUL_SAT_EN
    localparam int unsigned DW = PW + 1;
`else
    localparam int unsigned DW = OUT_W;
`endif

    logic                 w_adv;
    logic                 w_acc;
    logic [PW-1:0]        w_ax;
    logic [PW-1:0]        w_bx;
    logic [DW-1:0]        w_d;
    logic [NUM_STAGE-1:0] r_vld;
    logic [NUM_STAGE-1:0] w_vld_n;
    logic [DW-1:0]        r_d [NUM_STAGE];
    logic                 r_out_valid;
    logic                 w_out_valid_n;
    logic [OUT_W-1:0]     r_out_data;
    logic [OUT_W-1:0]     w_nar;
    logic                 r_out_sat;
    logic                 w_sat;
    logic                 r_busy;

    assign w_adv    = ce & (~r_out_valid | out_ready);
    assign in_ready = w_adv & reset;
    assign w_acc    = in_valid & in_ready;

    // Extending both operands to the full product width makes the low PW bits
    // of a plain multiply correct for both signed and unsigned samples.
    assign w_ax = in_signed ? {{B_W{in_a[A_W-1]}}, in_a} : {{B_W{1'b0}}, in_a};
    assign w_bx = in_signed ? {{A_W{in_b[B_W-1]}}, in_b} : {{A_W{1'b0}}, in_b};

`ifdef FN1_MUL_SAT_EN
    assign w_d = {in_signed, PW'(w_ax * w_bx)};
`else
    assign w_d = OUT_W'(w_ax * w_bx);
`endif

    // Next valid pattern: whole pipe shifts on adv, otherwise holds.
    always_comb begin
        w_vld_n       = r_vld;
        w_out_valid_n = r_out_valid;
        if (w_adv) begin
            w_vld_n[0] = w_acc;
            for (int i = 1; i < int'(NUM_STAGE); i++) begin
                w_vld_n[i] = r_vld[i-1];
            end
            w_out_valid_n = r_vld[NUM_STAGE-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_vld       <= w_vld_n;
            r_out_valid <= w_out_valid_n;
            r_busy      <= (|w_vld_n) | w_out_valid_n;
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_d[0] <= w_d;
            for (int i = 1; i < int'(NUM_STAGE); i++) begin
                r_d[i] <= r_d[i-1];
            end
        end
    end

`ifdef FN1_MUL_SAT_EN
    logic [PW-1:0] w_fin_p;
    logic          w_fin_s;

    assign w_fin_p = r_d[NUM_STAGE-1][PW-1:0];
    assign w_fin_s = r_d[NUM_STAGE-1][PW];

    if (OUT_W < PW) begin : g_sat
        logic [PW-OUT_W:0]   w_hs;
        logic [PW-OUT_W-1:0] w_hu;
        logic [OUT_W-1:0]    w_smin;
        logic                w_ovf;

        // Signed fits when all bits from OUT_W-1 up agree; unsigned when bits above OUT_W-1 are 0.
        always_comb begin
            w_hs   = w_fin_p[PW-1:OUT_W-1];
            w_hu   = w_fin_p[PW-1:OUT_W];
            w_smin = OUT_W'(1) << (OUT_W - 1);
            w_ovf  = w_fin_s ? ~((&w_hs) | ~(|w_hs)) : (|w_hu);
            w_sat  = w_ovf;
            w_nar  = w_fin_p[OUT_W-1:0];
            if (w_ovf) begin
                if (w_fin_s) begin
                    w_nar = w_fin_p[PW-1] ? w_smin : ~w_smin;
                end else begin
                    w_nar = '1;
                end
            end
        end
    end else begin : g_full
        assign w_nar = w_fin_p;
        assign w_sat = 1'b0;
    end
`else
    assign w_nar = r_d[NUM_STAGE-1];
    assign w_sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_adv) begin
            r_out_data <= w_nar;
            r_out_sat  <= w_sat;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fn1_mul_pipe_hs.sv
// Self-checking bench for fn1_mul_pipe_hs: vector table, directed handshake corners,
// and randomized traffic against a queue-based arithmetic reference model.
module tb_fn1_mul_pipe_hs;

    localparam int unsigned A_W       = 14;
    localparam int unsigned B_W       = 14;
    localparam int unsigned OUT_W     = 14;
    localparam int unsigned NUM_STAGE = 4;

    logic             clk;
    logic             reset;
    logic             ce;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_signed;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic             busy;

    fn1_mul_pipe_hs #(
        .A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .NUM_STAGE(NUM_STAGE)
    ) dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] a;
        logic [13:0] b;
        logic        s;
        logic [13:0] dw;
        logic [13:0] ds;
        logic        ss;
    } vec_t;

    localparam int NV = 14;
    vec_t        tbl [NV];
    int          n_tests;
    int          n_fail;
    logic [14:0] q [$];
    int          cyc;
    bit          last_acc;
    bit          last_xfer;
    bit          hold_pending;
    logic [13:0] hold_d;
    logic        hold_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact integer product, then wrap or clamp to the output range.
    function automatic logic [14:0] model(input logic [13:0] a, input logic [13:0] b, input logic s);
        longint pa;
        longint pb;
        longint p;
        longint lo;
        longint hi;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        p  = pa * pb;
`ifdef FN1_MUL_SAT_EN
        lo = s ? -(64'sd1 <<< (OUT_W - 1)) : 0;
        hi = s ? (64'sd1 <<< (OUT_W - 1)) - 1 : (64'sd1 <<< OUT_W) - 1;
        if (p > hi) return {1'b1, 14'(hi)};
        if (p < lo) return {1'b1, 14'(lo)};
`else
        lo = 0;
        hi = 0;
`endif
        return {1'b0, 14'(p)};
    endfunction

    // One clock: sample at mid-cycle, update scoreboard, advance past the next rising edge.
    task automatic step();
        logic [14:0] e;
        #4;
        chk("busy_vs_inflight", 32'(busy), 32'(q.size() != 0));
        if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_data), 32'(hold_d));
            chk("hold_sat", 32'(out_sat), 32'(hold_s));
        end
        last_acc     = in_valid & in_ready;
        last_xfer    = out_valid & out_ready & ce;
        hold_pending = out_valid & ~last_xfer & reset;
        hold_d       = out_data;
        hold_s       = out_sat;
        if (last_xfer) begin
            chk("sb_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_data", 32'(out_data), 32'(e[13:0]));
                chk("sb_sat", 32'(out_sat), 32'(e[14]));
            end
        end
        if (last_acc) q.push_back(model(in_a, in_b, in_signed));
        if (!reset) q.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        ce        = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && (q.size() != 0 || out_valid); i++) step();
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int a0;
        int idx;
        int ndel;
        int stall_left;
        bit started;
        int nov;

        n_tests = 0; n_fail = 0; cyc = 0; hold_pending = 0;
        tbl[0]  = '{14'h3FFD, 14'h0005, 1'b1, 14'h3FF1, 14'h3FF1, 1'b0};
        tbl[1]  = '{14'h0064, 14'h00C8, 1'b1, 14'h0E20, 14'h1FFF, 1'b1};
        tbl[2]  = '{14'h0064, 14'h00C8, 1'b0, 14'h0E20, 14'h3FFF, 1'b1};
        tbl[3]  = '{14'h3FFF, 14'h3FFF, 1'b1, 14'h0001, 14'h0001, 1'b0};
        tbl[4]  = '{14'h3FFF, 14'h3FFF, 1'b0, 14'h0001, 14'h3FFF, 1'b1};
        tbl[5]  = '{14'h2000, 14'h2000, 1'b1, 14'h0000, 14'h1FFF, 1'b1};
        tbl[6]  = '{14'h2000, 14'h0001, 1'b1, 14'h2000, 14'h2000, 1'b0};
        tbl[7]  = '{14'h1FFF, 14'h0001, 1'b1, 14'h1FFF, 14'h1FFF, 1'b0};
        tbl[8]  = '{14'h2000, 14'h3FFF, 1'b1, 14'h2000, 14'h1FFF, 1'b1};
        tbl[9]  = '{14'h0000, 14'h3FFF, 1'b0, 14'h0000, 14'h0000, 1'b0};
        tbl[10] = '{14'h0007, 14'h0009, 1'b0, 14'h003F, 14'h003F, 1'b0};
        tbl[11] = '{14'h1FFF, 14'h3FFF, 1'b1, 14'h2001, 14'h2001, 1'b0};
        tbl[12] = '{14'h0080, 14'h0080, 1'b0, 14'h0000, 14'h3FFF, 1'b1};
        tbl[13] = '{14'h007F, 14'h0081, 1'b0, 14'h3FFF, 14'h3FFF, 1'b0};

        reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Vector table: each sample in isolation, latency measured edge to edge.
        for (int v = 0; v < NV; v++) begin
            in_valid = 1'b1; in_a = tbl[v].a; in_b = tbl[v].b; in_signed = tbl[v].s;
            step();
            chk("tbl_accept", 32'(last_acc), 32'd1);
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            chk("tbl_latency", 32'(lat), 32'(NUM_STAGE));
`ifdef FN1_MUL_SAT_EN
            chk("tbl_data", 32'(out_data), 32'(tbl[v].ds));
            chk("tbl_sat", 32'(out_sat), 32'(tbl[v].ss));
`else
            chk("tbl_data", 32'(out_data), 32'(tbl[v].dw));
            chk("tbl_sat", 32'(out_sat), 32'd0);
`endif
        end
        drain();

        // Back-to-back stream with a 3-cycle consumer stall once output appears.
        idx = 0; ndel = 0; stall_left = 0; started = 0;
        for (int c = 0; c < 80 && (idx < 8 || q.size() != 0); c++) begin
            in_valid = (idx < 8); in_a = 14'(idx); in_b = 14'(idx + 1); in_signed = 1'b0;
            if (!started && out_valid) begin
                started = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            #1;
            if (stall_left > 0) chk("stall_in_ready", 32'(in_ready), 32'd0);
            step();
            if (last_acc) idx++;
            if (last_xfer) ndel++;
            if (stall_left > 0) stall_left--;
        end
        chk("stream_delivered", 32'(ndel), 32'd8);
        drain();

        // Clock-enable freeze with 3 samples in flight.
        a0 = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 14'(i + 10); in_b = 14'h3FF0 + 14'(i); in_signed = 1'b1;
            step();
            if (i == 0) a0 = cyc;
        end
        in_valid = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("ce0_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("ce0_out_valid", 32'(out_valid), 32'd0);
        end
        ce = 1'b1;
        lat = 0;
        while (!out_valid && lat < 30) begin
            step();
            lat++;
        end
        chk("ce0_latency", 32'(cyc - a0), 32'(NUM_STAGE + 5));
        drain();

        // Reset with 4 samples in flight.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 14'(i + 3); in_b = 14'(i + 7); in_signed = 1'b0;
            step();
        end
        in_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("rst_mid_in_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        in_valid = 1'b0;
        nov = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) nov++;
        end
        chk("rst_no_stale", 32'(nov), 32'd0);

        // Alternating signed/unsigned all-ones operands in flight together.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_a = 14'h3FFF; in_b = 14'h3FFF; in_signed = ~i[0];
            step();
        end
        drain();

        // Randomized traffic with random ce and consumer stalls.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 14'($urandom);
            in_b      = 14'($urandom);
            in_signed = 1'($urandom);
            ce        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
